filtro_antirrebote: RTL and testbench

Per-bit synchroniser and debounce filter for the board's raw push-button/switch inputs. It is the stage directly upstream of the sum-of-products logic: its registered `Entrada` bus drives that block's 4-bit `Entrada` input, so the combinational function only ever sees clean, clock-aligned levels. It also emits single-cycle rise/fall pulses per bit for any consumer that needs edges rather than levels.

---
 rtl/filtro_antirrebote.sv | 115 +++++++++++
 tb/tb_filtro_antirrebote.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/filtro_antirrebote.sv
// filtro_antirrebote: per-bit synchroniser and debounce filter for raw
// push-button and switch inputs. The registered Entrada bus feeds the
// sum-of-products block, so that logic only ever sees clean levels that are
// aligned to Reloj.
//
// Parameters
//   ANCHO          number of independent input bits
//   CUENTA_ESTABLE consecutive differing cycles needed before a level change (>= 2)
// Ports
//   Reloj        system clock, rising edge
//   Reset        asynchronous, active-high; clears all state
//   EntradaCruda raw, bouncy, asynchronous inputs
//   Entrada      debounced registered levels
//   Subida       one-cycle pulse per bit on a 0->1 change of Entrada
//   Bajada       one-cycle pulse per bit on a 1->0 change of Entrada
//   Estable      high when no bit has a transition pending (all counters zero)

// filtro_canal: a single debounce channel.
//   cruda   raw input bit
//   nivel   filtered level
//   subida  rise pulse
//   bajada  fall pulse
//   ocupado counter non-zero (transition pending)
module filtro_canal #(
  parameter int CUENTA_ESTABLE = 50000
) (
  input  logic Reloj,
  input  logic Reset,
  input  logic cruda,
  output logic nivel,
  output logic subida,
  output logic bajada,
  output logic ocupado
);
  localparam int CW = (CUENTA_ESTABLE > 2) ? $clog2(CUENTA_ESTABLE) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(CUENTA_ESTABLE - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          nivel_nxt, subida_nxt, bajada_nxt;

  // Two-flop synchroniser; only s2 is safe to use.
  always_ff @(posedge Reloj or posedge Reset) begin
    if (Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= cruda;
      s2 <= s1;
    end
  end

  // Any sample that agrees with the filtered level restarts the run, so a
  // single bounce anywhere before the terminal count is rejected.
  always_comb begin
    cnt_nxt    = '0;
    nivel_nxt  = nivel;
    subida_nxt = 1'b0;
    bajada_nxt = 1'b0;
    if (s2 != nivel) begin
      if (cnt == TERMINAL) begin
        nivel_nxt  = s2;
        subida_nxt = s2;
        bajada_nxt = ~s2;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge Reloj or posedge Reset) begin
    if (Reset) begin
      cnt    <= '0;
      nivel  <= 1'b0;
      subida <= 1'b0;
      bajada <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      nivel  <= nivel_nxt;
      subida <= subida_nxt;
      bajada <= bajada_nxt;
    end
  end

  assign ocupado = |cnt;
endmodule

module filtro_antirrebote #(
  parameter int ANCHO          = 4,
  parameter int CUENTA_ESTABLE = 50000
) (
  input  logic             Reloj,
  input  logic             Reset,
  input  logic [ANCHO-1:0] EntradaCruda,
  output logic [ANCHO-1:0] Entrada,
  output logic [ANCHO-1:0] Subida,
  output logic [ANCHO-1:0] Bajada,
  output logic             Estable
);
  logic [ANCHO-1:0] ocupado;

  // Channels are fully independent; one instance per bit.
  filtro_canal #(.CUENTA_ESTABLE(CUENTA_ESTABLE)) u_canal [ANCHO-1:0] (
    .Reloj   (Reloj),
    .Reset   (Reset),
    .cruda   (EntradaCruda),
    .nivel   (Entrada),
    .subida  (Subida),
    .bajada  (Bajada),
    .ocupado (ocupado)
  );

  // NOR over every counter bit of every channel.
  assign Estable = ~|ocupado;
endmodule

// File: tb/tb_filtro_antirrebote.sv
// Testbench for filtro_antirrebote (ANCHO=4, CUENTA_ESTABLE=4).
// The stimulus process drives inputs and pushes the expected outputs into a
// queue; a monitor on the falling edge pops and compares. The reference model
// keeps the synchronised sample history and flips a bit only when its last N
// samples all differ from the filtered level.
module tb_filtro_antirrebote;
  localparam int ANCHO = 4;
  localparam int N     = 4;

  logic             Reloj = 1'b0;
  logic             Reset = 1'b1;
  logic [ANCHO-1:0] EntradaCruda = '1;
  logic [ANCHO-1:0] Entrada, Subida, Bajada;
  logic             Estable;

  filtro_antirrebote #(.ANCHO(ANCHO), .CUENTA_ESTABLE(N)) dut (
    .Reloj        (Reloj),
    .Reset        (Reset),
    .EntradaCruda (EntradaCruda),
    .Entrada      (Entrada),
    .Subida       (Subida),
    .Bajada       (Bajada),
    .Estable      (Estable)
  );

  always #5 Reloj = ~Reloj;

  typedef struct packed {
    logic [ANCHO-1:0] ent;
    logic [ANCHO-1:0] sub;
    logic [ANCHO-1:0] baj;
    logic             est;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state.
  logic [ANCHO-1:0] filt, sub_m, baj_m;
  logic             est_m;
  logic [ANCHO-1:0] raw_q[$];  // raw values captured by the synchroniser, oldest first
  logic [ANCHO-1:0] s2_q[$];   // last N synchronised samples seen at edges

  task automatic model_reset();
    filt  = '0;
    sub_m = '0;
    baj_m = '0;
    est_m = 1'b1;
    raw_q = {};
    raw_q.push_back('0);
    raw_q.push_back('0);
    s2_q  = {};
  endtask

  task automatic model_edge(input logic [ANCHO-1:0] raw);
    logic [ANCHO-1:0] samp;
    logic             flip;
    samp = raw_q.pop_front();
    raw_q.push_back(raw);
    s2_q.push_back(samp);
    if (s2_q.size() > N) void'(s2_q.pop_front());
    est_m = 1'b1;
    for (int i = 0; i < ANCHO; i++) begin
      flip = (s2_q.size() == N);
      foreach (s2_q[j]) if (s2_q[j][i] == filt[i]) flip = 1'b0;
      sub_m[i] = flip & samp[i];
      baj_m[i] = flip & ~samp[i];
      if (flip) filt[i] = samp[i];
      if (samp[i] != filt[i]) est_m = 1'b0;
    end
  endtask

  function automatic exp_t cur();
    exp_t e;
    e.ent = filt;
    e.sub = sub_m;
    e.baj = baj_m;
    e.est = est_m;
    return e;
  endfunction

  // One clock cycle: drive inputs just after a rising edge, record what the
  // DUT should show at the coming falling edge, then advance the model.
  task automatic cyc(input logic r, input logic [ANCHO-1:0] raw);
    Reset        = r;
    EntradaCruda = raw;
    if (r) model_reset();
    q.push_back(cur());
    @(posedge Reloj);
    if (!r) model_edge(raw);
    #1;
  endtask

  task automatic chk(input string nm, input logic [ANCHO-1:0] act, input logic [ANCHO-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: compares whenever the stimulus side has an expectation queued.
  always @(negedge Reloj) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("entrada", Entrada, e.ent);
      chk("subida",  Subida,  e.sub);
      chk("bajada",  Bajada,  e.baj);
      chk("estable", {{(ANCHO-1){1'b0}}, Estable}, {{(ANCHO-1){1'b0}}, e.est});
    end
  end

  initial begin
    logic [ANCHO-1:0] v, m;
    logic [7:0]       pat;
    model_reset();
    @(posedge Reloj);
    #1;
    // Reset with all raw inputs high, then release: rise on the 6th edge.
    repeat (3) cyc(1'b1, 4'hF);
    repeat (10) cyc(1'b0, 4'hF);
    repeat (10) cyc(1'b0, 4'h0);
    // Clean rise on bit 0.
    repeat (10) cyc(1'b0, 4'h1);
    // Bounce on bit 2: 1,1,1,0,1,1,1,1 then hold.
    pat = 8'b1111_0111;  // bit k is cycle k
    for (int k = 0; k < 8; k++) begin
      v = 4'h1;
      v[2] = pat[k];
      cyc(1'b0, v);
    end
    repeat (6) cyc(1'b0, 4'h5);
    // Simultaneous opposite events.
    repeat (10) cyc(1'b0, 4'h3);
    repeat (10) cyc(1'b0, 4'hC);
    // Reset mid-count on bit 1.
    repeat (10) cyc(1'b0, 4'h0);
    repeat (4) cyc(1'b0, 4'h2);
    cyc(1'b1, 4'h2);
    repeat (10) cyc(1'b0, 4'h2);
    // Long hold: no further activity.
    repeat (100) cyc(1'b0, 4'h2);
    // Randomised phases with bounces and occasional resets.
    for (int p = 0; p < 60; p++) begin
      v = 4'($urandom);
      for (int c = 0, len = $urandom_range(1, 9); c < len; c++) begin
        for (int i = 0; i < ANCHO; i++) m[i] = ($urandom_range(7) == 0);
        cyc(($urandom_range(59) == 0), v ^ m);
      end
    end
    repeat (8) cyc(1'b0, 4'h9);
    @(negedge Reloj);
    #1;
    chk("drain", 4'(q.size()), 4'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
